// File: rtl/neighbor_link_cfg_if.sv
// Signal bundle between the decoder grid (master) and one neighbour link (slave):
// stage/config inputs, growth/peel status, and the side A <-> side B cluster exchange.
interface neighbor_link_cfg_if #(
  parameter int ADDRESS_WIDTH = 9,
  parameter int WEIGHT_WIDTH  = 4,
  parameter int STAGE_WIDTH   = 3
);
  logic [STAGE_WIDTH-1:0]   global_stage;
  logic                     cfg_valid;
  logic [WEIGHT_WIDTH-1:0]  weight_in;
  logic [1:0]               mode_in;
  logic                     a_increase;
  logic                     b_increase;
  logic                     a_peel_in;
  logic                     b_peel_in;
  logic                     fully_grown;
  logic                     is_boundary;
  logic                     newly_grown;
  logic                     is_error;
  logic [ADDRESS_WIDTH-1:0] a_root_in;
  logic [ADDRESS_WIDTH-1:0] b_root_in;
  logic [ADDRESS_WIDTH-1:0] a_root_out;
  logic [ADDRESS_WIDTH-1:0] b_root_out;
  logic a_parent_vector_in,  b_parent_vector_in,  a_parent_vector_out,  b_parent_vector_out;
  logic a_parent_odd_in,     b_parent_odd_in,     a_parent_odd_out,     b_parent_odd_out;
  logic a_child_cluster_parity_in,  b_child_cluster_parity_in;
  logic a_child_cluster_parity_out, b_child_cluster_parity_out;
  logic a_child_touching_boundary_in,  b_child_touching_boundary_in;
  logic a_child_touching_boundary_out, b_child_touching_boundary_out;

  modport master (
    output global_stage, cfg_valid, weight_in, mode_in,
    output a_increase, b_increase, a_peel_in, b_peel_in,
    input  fully_grown, is_boundary, newly_grown, is_error,
    output a_root_in, b_root_in, input a_root_out, b_root_out,
    output a_parent_vector_in, b_parent_vector_in, input a_parent_vector_out, b_parent_vector_out,
    output a_parent_odd_in, b_parent_odd_in, input a_parent_odd_out, b_parent_odd_out,
    output a_child_cluster_parity_in, b_child_cluster_parity_in,
    input  a_child_cluster_parity_out, b_child_cluster_parity_out,
    output a_child_touching_boundary_in, b_child_touching_boundary_in,
    input  a_child_touching_boundary_out, b_child_touching_boundary_out
  );

  modport slave (
    input  global_stage, cfg_valid, weight_in, mode_in,
    input  a_increase, b_increase, a_peel_in, b_peel_in,
    output fully_grown, is_boundary, newly_grown, is_error,
    input  a_root_in, b_root_in, output a_root_out, b_root_out,
    input  a_parent_vector_in, b_parent_vector_in, output a_parent_vector_out, b_parent_vector_out,
    input  a_parent_odd_in, b_parent_odd_in, output a_parent_odd_out, b_parent_odd_out,
    input  a_child_cluster_parity_in, b_child_cluster_parity_in,
    output a_child_cluster_parity_out, b_child_cluster_parity_out,
    input  a_child_touching_boundary_in, b_child_touching_boundary_in,
    output a_child_touching_boundary_out, b_child_touching_boundary_out
  );
endinterface

// File: rtl/neighbor_link_cfg.sv
// Runtime-configurable union-find edge link: per-round weight/mode, saturating growth,
// peeling error flag and A/B exchange. Define NEIGHBOR_LINK_PIPE_EN to register the exchange.
module neighbor_link_cfg #(
  parameter int                ADDRESS_WIDTH  = 9,
  parameter int                WEIGHT_WIDTH   = 4,
  parameter int                STAGE_WIDTH    = 3,
  parameter logic [WEIGHT_WIDTH-1:0] DEFAULT_WEIGHT = 2,
  parameter logic [1:0]        DEFAULT_MODE   = 2'd0,
  parameter logic [STAGE_WIDTH-1:0] STAGE_MEASUREMENT_LOADING = 3'd1,
  parameter logic [STAGE_WIDTH-1:0] STAGE_GROW                = 3'd2,
  parameter logic [STAGE_WIDTH-1:0] STAGE_PEELING             = 3'd4
) (
  input  logic                    clk,
  input  logic                    reset,
  neighbor_link_cfg_if.slave      link,
  output logic [WEIGHT_WIDTH-1:0] dbg_growth_o,
  output logic [WEIGHT_WIDTH-1:0] dbg_weight_o,
  output logic [1:0]              dbg_mode_o
);
  logic [WEIGHT_WIDTH-1:0] weight_q, weight_d;
  logic [1:0]              mode_q, mode_d;
  logic [WEIGHT_WIDTH-1:0] growth_q, growth_d;
  logic                    error_q, error_d;
  logic                    grown_q;
  logic                    newly_q;
  logic [WEIGHT_WIDTH:0]   sum;
  logic [WEIGHT_WIDTH:0]   a_ext, b_ext;
  logic                    fully_grown;
  logic                    loading, growing, peeling;

  assign loading = (link.global_stage == STAGE_MEASUREMENT_LOADING);
  assign growing = (link.global_stage == STAGE_GROW);
  assign peeling = (link.global_stage == STAGE_PEELING);

  assign fully_grown = (mode_q < 2'd2) && (growth_q >= weight_q);
  assign a_ext = {{WEIGHT_WIDTH{1'b0}}, link.a_increase};
  assign b_ext = (mode_q == 2'd0) ? {{WEIGHT_WIDTH{1'b0}}, link.b_increase} : '0;
  assign sum   = {1'b0, growth_q} + a_ext + b_ext;

  always_comb begin
    weight_d = weight_q;
    mode_d   = mode_q;
    growth_d = growth_q;
    error_d  = error_q;
    if (loading) begin
      growth_d = '0;
      error_d  = 1'b0;
      if (link.cfg_valid) begin
        weight_d = link.weight_in;
        mode_d   = link.mode_in;
      end
    end else if (growing) begin
      // Absent edges (mode 2/3) never grow; the wide sum keeps saturation overflow-free.
      if (mode_q >= 2'd2)
        growth_d = '0;
      else if (sum > {1'b0, weight_q})
        growth_d = weight_q;
      else
        growth_d = sum[WEIGHT_WIDTH-1:0];
    end else if (peeling && fully_grown) begin
      error_d = error_q ^ link.a_peel_in ^ link.b_peel_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      weight_q <= DEFAULT_WEIGHT;
      mode_q   <= DEFAULT_MODE;
      growth_q <= '0;
      error_q  <= 1'b0;
      grown_q  <= 1'b0;
      newly_q  <= 1'b0;
    end else begin
      weight_q <= weight_d;
      mode_q   <= mode_d;
      growth_q <= growth_d;
      error_q  <= error_d;
      grown_q  <= fully_grown;
      newly_q  <= fully_grown && !grown_q;
    end
  end

  assign link.fully_grown = fully_grown;
  assign link.is_boundary = (mode_q == 2'd1) && fully_grown;
  assign link.newly_grown = newly_q;
  assign link.is_error    = error_q;

  assign dbg_growth_o = growth_q;
  assign dbg_weight_o = weight_q;
  assign dbg_mode_o   = mode_q;

`ifdef NEIGHBOR_LINK_PIPE_EN
  // Registered exchange for long links; parent_vector gate samples mode_q at capture.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      link.a_root_out                    <= '0;
      link.b_root_out                    <= '0;
      link.a_parent_vector_out           <= 1'b0;
      link.b_parent_vector_out           <= 1'b0;
      link.a_parent_odd_out              <= 1'b0;
      link.b_parent_odd_out              <= 1'b0;
      link.a_child_cluster_parity_out    <= 1'b0;
      link.b_child_cluster_parity_out    <= 1'b0;
      link.a_child_touching_boundary_out <= 1'b0;
      link.b_child_touching_boundary_out <= 1'b0;
    end else begin
      link.a_root_out                    <= link.b_root_in;
      link.b_root_out                    <= link.a_root_in;
      link.a_parent_vector_out           <= (mode_q == 2'd0) && link.b_parent_vector_in;
      link.b_parent_vector_out           <= (mode_q == 2'd0) && link.a_parent_vector_in;
      link.a_parent_odd_out              <= link.b_parent_odd_in;
      link.b_parent_odd_out              <= link.a_parent_odd_in;
      link.a_child_cluster_parity_out    <= link.b_child_cluster_parity_in;
      link.b_child_cluster_parity_out    <= link.a_child_cluster_parity_in;
      link.a_child_touching_boundary_out <= link.b_child_touching_boundary_in;
      link.b_child_touching_boundary_out <= link.a_child_touching_boundary_in;
    end
  end
`else
  assign link.a_root_out                    = link.b_root_in;
  assign link.b_root_out                    = link.a_root_in;
  assign link.a_parent_vector_out           = (mode_q == 2'd0) && link.b_parent_vector_in;
  assign link.b_parent_vector_out           = (mode_q == 2'd0) && link.a_parent_vector_in;
  assign link.a_parent_odd_out              = link.b_parent_odd_in;
  assign link.b_parent_odd_out              = link.a_parent_odd_in;
  assign link.a_child_cluster_parity_out    = link.b_child_cluster_parity_in;
  assign link.b_child_cluster_parity_out    = link.a_child_cluster_parity_in;
  assign link.a_child_touching_boundary_out = link.b_child_touching_boundary_in;
  assign link.b_child_touching_boundary_out = link.a_child_touching_boundary_in;
`endif

endmodule
